// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor. A single full-adder cell and a
// carry flip-flop process one operand bit per clock, LSB first. Results are
// registered at completion and announced with a one-cycle done strobe.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic             c_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    // Full-adder cell on the current operand LSBs and the carry flip-flop.
    logic             fa_sum_d;
    logic             fa_cout_d;
    logic [WIDTH-1:0] sum_sh_d;
    logic             last_bit_d;

    assign fa_sum_d   = a_q[0] ^ b_q[0] ^ c_q;
    assign fa_cout_d  = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
    // Written as a wide shift so it stays legal for WIDTH = 1.
    assign sum_sh_d   = WIDTH'({fa_sum_d, sum_sh_q} >> 1);
    assign last_bit_d = (cnt_q == CNT_W'(WIDTH - 1));

    // Control FSM plus datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_sh_q <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b, force carry-in.
                        a_q      <= a;
                        b_q      <= sub ? ~b : b;
                        c_q      <= sub ? 1'b1 : cin;
                        sum_sh_q <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    c_q      <= fa_cout_d;
                    sum_sh_q <= sum_sh_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_bit_d) begin
                        // On the MSB, c_q is the carry into the MSB, so the
                        // signed overflow is simply c_q XOR the final carry.
                        sum_q   <= sum_sh_d;
                        carry_q <= fa_cout_d;
                        ovf_q   <= c_q ^ fa_cout_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed table vectors and multi-cycle sequences on an
// 8-bit instance, plus random operands on 1-bit and 32-bit instances checked
// against an arithmetic reference model.
module tb_serial_adder;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       start8, cin8, sub8, busy8, done8, carry8, ovf8;
    logic [7:0] a8, b8, sum8;
    // 1-bit instance
    logic       start1, cin1, sub1, busy1, done1, carry1, ovf1;
    logic [0:0] a1, b1, sum1;
    // 32-bit instance
    logic        start32, cin32, sub32, busy32, done32, carry32, ovf32;
    logic [31:0] a32, b32, sum32;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .overflow(ovf8)
    );
    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .busy(busy1), .done(done1), .sum(sum1), .carry(carry1), .overflow(ovf1)
    );
    serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .cin(cin32), .sub(sub32),
        .busy(busy32), .done(done32), .sum(sum32), .carry(carry32), .overflow(ovf32)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic void ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                      input logic cin, input logic sub,
                                      output logic [31:0] s, output logic c, output logic v);
        longint unsigned m   = (64'd1 << w) - 64'd1;
        longint unsigned ua  = {32'd0, a} & m;
        longint unsigned ub  = {32'd0, b} & m;
        longint unsigned tot;
        longint sa, sb, r, lo, hi;
        tot = sub ? (ua + (~ub & m) + 64'd1) : (ua + ub + {63'd0, cin});
        s   = 32'(tot & m);
        c   = ((tot >> w) & 64'd1) != 64'd0;
        sa  = ua[w-1] ? (longint'(ua) - (longint'(1) << w)) : longint'(ua);
        sb  = ub[w-1] ? (longint'(ub) - (longint'(1) << w)) : longint'(ub);
        r   = sub ? (sa - sb) : (sa + sb + longint'({63'd0, cin}));
        lo  = -(longint'(1) << (w - 1));
        hi  = (longint'(1) << (w - 1)) - 1;
        v   = (r < lo) || (r > hi);
    endfunction

    // One 8-bit operation; lat counts clock windows after the accepting edge
    // until done is seen (done in window WIDTH+1 means latency WIDTH+1).
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, output int lat);
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b; cin8 = cin; sub8 = sub;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
        lat = 1;
        while (!done8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       v;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat;
        int cyc;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[7] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};

        rst = 1'b1;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
        start1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0;
        start32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset busy", {31'd0, busy8}, 32'd0);
        check("reset done", {31'd0, done8}, 32'd0);
        check("reset sum", {24'd0, sum8}, 32'd0);
        check("reset carry", {31'd0, carry8}, 32'd0);
        check("reset overflow", {31'd0, ovf8}, 32'd0);
        check("reset sum32", sum32, 32'd0);

        // Directed table on the 8-bit instance
        for (int i = 0; i < 8; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
            $display("vec %0d: a=%02h b=%02h cin=%0b sub=%0b -> sum=%02h carry=%0b ovf=%0b lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, sum8, carry8, ovf8, lat);
            check("vec latency", lat, 32'd9);
            check("vec done", {31'd0, done8}, 32'd1);
            check("vec sum", {24'd0, sum8}, {24'd0, vecs[i].s});
            check("vec carry", {31'd0, carry8}, {31'd0, vecs[i].c});
            check("vec overflow", {31'd0, ovf8}, {31'd0, vecs[i].v});
        end

        // Reset three cycles into an operation aborts it
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; sub8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        check("abort busy before rst", {31'd0, busy8}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("abort: busy=%0b done=%0b sum=%02h", busy8, done8, sum8);
        check("abort busy", {31'd0, busy8}, 32'd0);
        check("abort done", {31'd0, done8}, 32'd0);
        check("abort sum", {24'd0, sum8}, 32'd0);
        check("abort carry", {31'd0, carry8}, 32'd0);
        op8(8'h01, 8'h01, 1'b0, 1'b0, lat);
        $display("after abort: 01+01 -> sum=%02h lat=%0d", sum8, lat);
        check("post-abort latency", lat, 32'd9);
        check("post-abort sum", {24'd0, sum8}, 32'h02);

        // start held through RUN with changing operands; back-to-back in DONE
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0;
        @(posedge clk);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done8) break;
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
        end
        $display("held start: first done at cycle %0d sum=%02h", cyc, sum8);
        check("held first done cycle", cyc, 32'd9);
        check("held first sum", {24'd0, sum8}, 32'h33);
        check("held first carry", {31'd0, carry8}, 32'd0);
        a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; sub8 = 1'b0;
        @(negedge clk);
        cyc++;
        start8 = 1'b0;
        check("b2b done drops", {31'd0, done8}, 32'd0);
        check("b2b busy", {31'd0, busy8}, 32'd1);
        check("b2b sum held", {24'd0, sum8}, 32'h33);
        a8 = 8'($urandom); b8 = 8'($urandom);
        while (!done8 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        $display("held start: second done at cycle %0d sum=%02h", cyc, sum8);
        check("b2b second done cycle", cyc, 32'd18);
        check("b2b second sum", {24'd0, sum8}, 32'h07);

        // Random operands on the 1-bit and 32-bit instances in parallel
        fork
            begin : rand_w1
                logic [31:0] es; logic ec, ev; logic ra, rb, rc, rs; int l;
                for (int i = 0; i < 1000; i++) begin
                    @(negedge clk);
                    ra = 1'($urandom); rb = 1'($urandom); rc = 1'($urandom); rs = 1'($urandom);
                    start1 = 1'b1; a1 = ra; b1 = rb; cin1 = rc; sub1 = rs;
                    ref_model(1, {31'd0, ra}, {31'd0, rb}, rc, rs, es, ec, ev);
                    @(posedge clk);
                    @(negedge clk);
                    start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom);
                    cin1 = 1'($urandom); sub1 = 1'($urandom);
                    l = 1;
                    while (!done1 && l < 50) begin
                        @(negedge clk);
                        l++;
                    end
                    $display("w1 #%0d: a=%0b b=%0b cin=%0b sub=%0b -> sum=%0b carry=%0b ovf=%0b lat=%0d",
                             i, ra, rb, rc, rs, sum1, carry1, ovf1, l);
                    check("w1 latency", l, 32'd2);
                    check("w1 sum", {31'd0, sum1}, es);
                    check("w1 carry", {31'd0, carry1}, {31'd0, ec});
                    check("w1 overflow", {31'd0, ovf1}, {31'd0, ev});
                end
            end
            begin : rand_w32
                logic [31:0] es; logic ec, ev; logic [31:0] ra, rb; logic rc, rs; int l;
                for (int i = 0; i < 1000; i++) begin
                    @(negedge clk);
                    ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
                    start32 = 1'b1; a32 = ra; b32 = rb; cin32 = rc; sub32 = rs;
                    ref_model(32, ra, rb, rc, rs, es, ec, ev);
                    @(posedge clk);
                    @(negedge clk);
                    start32 = 1'b0; a32 = $urandom; b32 = $urandom;
                    cin32 = 1'($urandom); sub32 = 1'($urandom);
                    l = 1;
                    while (!done32 && l < 100) begin
                        @(negedge clk);
                        l++;
                    end
                    $display("w32 #%0d: a=%08h b=%08h cin=%0b sub=%0b -> sum=%08h carry=%0b ovf=%0b lat=%0d",
                             i, ra, rb, rc, rs, sum32, carry32, ovf32, l);
                    check("w32 latency", l, 32'd33);
                    check("w32 sum", sum32, es);
                    check("w32 carry", {31'd0, carry32}, {31'd0, ec});
                    check("w32 overflow", {31'd0, ovf32}, {31'd0, ev});
                end
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
